seq_divider: RTL

Sequential restoring divider and the inverse of the team's 4x4 array multiplier. It takes a 2W-bit dividend, i.e. a product-width value, and a W-bit divisor. It returns a 2W-bit quotient and a W-bit remainder.
- One quotient bit is produced per clock, using a start/busy/done handshake.
- It sits beside the multiplier in the arithmetic datapath, so a multiply can be checked or undone.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_step.sv | 23 ++
 rtl/seq_divider.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding and default operand width.
package seq_divider_pkg;

  // Matches the operand width of the 4x4 array multiplier this divider undoes.
  localparam int DEF_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       borrow;

  assign shifted = {rem_in[W-1:0], bit_in};
  assign {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};

  // A set guard bit means the shifted value is already above any divisor, so subtraction always succeeds.
  assign q_bit   = rem_in[W] | ~borrow;
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*W);

  state_t         state;
  logic [CW-1:0]  count;
  logic [W:0]     prem;
  logic [2*W-1:0] qreg;
  logic [W-1:0]   dvsr;
  logic [W:0]     prem_next;
  logic           q_bit;

  div_step #(.W(W)) u_step (
    .rem_in  (prem),
    .bit_in  (qreg[2*W-1]),
    .divisor (dvsr),
    .rem_out (prem_next),
    .q_bit   (q_bit)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      prem        <= '0;
      qreg        <= '0;
      dvsr        <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count <= '0;
            prem  <= '0;
            qreg  <= dividend;
            dvsr  <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          prem  <= prem_next;
          qreg  <= {qreg[2*W-2:0], q_bit};
          count <= count + CW'(1);
          if (count == CW'(2*W-1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= {qreg[2*W-2:0], q_bit};
            remainder <= prem_next[W-1:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
